// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with occupancy count, live almost-full/empty thresholds and sticky error flags.
// Head shows one cycle after a push into empty or a pop; push when full only alongside a pop.
module sync_fifo_ctl #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 8,
    parameter bit OUT_REG    = 1'b0
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_wen,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ren,
    input  logic [ADDR_WIDTH:0]   i_af_thresh,
    input  logic [ADDR_WIDTH:0]   i_ae_thresh,
    input  logic                  i_err_clr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic                  o_overflow,
    output logic                  o_underflow
);
    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam int                CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]     CAP     = CW'(DEPTH + (OUT_REG ? 1 : 0));
    localparam logic [CW-1:0]     CNT_ONE = CW'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_vld_q, out_vld_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  rd, wr;
    logic                  ram_empty, load, bypass, ram_wr, ram_rd;
    logic [DATA_WIDTH-1:0] ram_head;

    assign o_empty   = (count_q == '0);
    assign o_full    = (count_q == CAP);
    assign rd        = i_ren & ~o_empty;
    assign wr        = i_wen & (~o_full | rd);
    assign ram_empty = (wptr_q == rptr_q);
    assign ram_head  = mem_q[rptr_q[ADDR_WIDTH-1:0]];

    // Registered head refills whenever it is vacant or popped; with the RAM empty it
    // captures the incoming push directly so a lone entry never sits in the RAM.
    assign load   = OUT_REG & (~out_vld_q | rd);
    assign bypass = load & ram_empty;
    assign ram_wr = wr & ~bypass;
    assign ram_rd = OUT_REG ? (load & ~ram_empty) : rd;

    assign wptr_d    = ram_wr ? wptr_q + CNT_ONE : wptr_q;
    assign rptr_d    = ram_rd ? rptr_q + CNT_ONE : rptr_q;
    assign out_vld_d = load ? (ram_empty ? wr : 1'b1) : out_vld_q;
    assign ovf_d     = (i_wen & ~wr) | (ovf_q & ~i_err_clr);
    assign unf_d     = (i_ren & o_empty) | (unf_q & ~i_err_clr);

    always_comb begin
        count_d = count_q;
        if (wr & ~rd) begin
            count_d = count_q + CNT_ONE;
        end else if (rd & ~wr) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Storage carries no reset; occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (ram_wr & ~i_rst) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= i_data;
        end
        if (load & ~i_rst) begin
            out_q <= ram_empty ? i_data : ram_head;
        end
    end

    assign o_data         = OUT_REG ? out_q : ram_head;
    assign o_count        = count_q;
    assign o_almost_full  = (count_q >= i_af_thresh);
    assign o_almost_empty = (count_q <= i_ae_thresh);
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Drives one shared stimulus stream into a combinational-head and a registered-head FIFO,
// each checked against its own queue scoreboard.
module tb_sync_fifo_ctl;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int CW = AW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_rst, i_wen, i_ren, i_err_clr;
    logic [DW-1:0] i_data;
    logic [CW-1:0] i_af_thresh, i_ae_thresh;

    logic [DW-1:0] dat [2];
    logic [CW-1:0] cnt [2];
    logic          emp [2];
    logic          ful [2];
    logic          afl [2];
    logic          ael [2];
    logic          ovf [2];
    logic          unf [2];

    sync_fifo_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1'b0)) dut0 (
        .clk(clk), .i_rst(i_rst), .i_wen(i_wen), .i_data(i_data), .i_ren(i_ren),
        .i_af_thresh(i_af_thresh), .i_ae_thresh(i_ae_thresh), .i_err_clr(i_err_clr),
        .o_data(dat[0]), .o_empty(emp[0]), .o_full(ful[0]), .o_count(cnt[0]),
        .o_almost_full(afl[0]), .o_almost_empty(ael[0]),
        .o_overflow(ovf[0]), .o_underflow(unf[0])
    );

    sync_fifo_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1'b1)) dut1 (
        .clk(clk), .i_rst(i_rst), .i_wen(i_wen), .i_data(i_data), .i_ren(i_ren),
        .i_af_thresh(i_af_thresh), .i_ae_thresh(i_ae_thresh), .i_err_clr(i_err_clr),
        .o_data(dat[1]), .o_empty(emp[1]), .o_full(ful[1]), .o_count(cnt[1]),
        .o_almost_full(afl[1]), .o_almost_empty(ael[1]),
        .o_overflow(ovf[1]), .o_underflow(unf[1])
    );

    int n_eval = 0;
    int n_fail = 0;

    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    bit            m_ovf [2];
    bit            m_unf [2];
    int            cap   [2] = '{4, 5};

    function automatic int msize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [DW-1:0] mhead(int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic mpush(int k, logic [DW-1:0] d);
        if (k == 0) q0.push_back(d);
        else        q1.push_back(d);
    endtask

    task automatic mpop(int k);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int k = 0; k < 2; k++) begin
            int s;
            s = msize(k);
            chk({tag, ".count"}, k, 32'(cnt[k]), 32'(s));
            chk({tag, ".empty"}, k, 32'(emp[k]), 32'(s == 0));
            chk({tag, ".full"},  k, 32'(ful[k]), 32'(s == cap[k]));
            chk({tag, ".afull"}, k, 32'(afl[k]), 32'(s >= int'(i_af_thresh)));
            chk({tag, ".aempty"}, k, 32'(ael[k]), 32'(s <= int'(i_ae_thresh)));
            chk({tag, ".ovf"},   k, 32'(ovf[k]), 32'(m_ovf[k]));
            chk({tag, ".unf"},   k, 32'(unf[k]), 32'(m_unf[k]));
            if (s > 0) chk({tag, ".head"}, k, 32'(dat[k]), 32'(mhead(k)));
        end
    endtask

    task automatic step(bit wen, logic [DW-1:0] d, bit ren, bit clr, string tag);
        bit rd [2];
        bit wr [2];
        bit ue [2];
        i_wen = wen; i_data = d; i_ren = ren; i_err_clr = clr;
        for (int k = 0; k < 2; k++) begin
            int s;
            s     = msize(k);
            rd[k] = ren && (s > 0);
            wr[k] = wen && ((s < cap[k]) || rd[k]);
            ue[k] = ren && (s == 0);
            if (rd[k]) chk({tag, ".popdat"}, k, 32'(dat[k]), 32'(mhead(k)));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_ovf[k] = (wen && !wr[k]) || (m_ovf[k] && !clr);
            m_unf[k] = ue[k] || (m_unf[k] && !clr);
            if (rd[k]) mpop(k);
            if (wr[k]) mpush(k, d);
        end
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(bit wen, string tag);
        i_rst = 1'b1; i_wen = wen; i_data = 16'hdead; i_ren = 1'b0; i_err_clr = 1'b0;
        @(posedge clk);
        #1;
        i_rst = 1'b0; i_wen = 1'b0;
        q0.delete();
        q1.delete();
        m_ovf = '{1'b0, 1'b0};
        m_unf = '{1'b0, 1'b0};
        check_all(tag);
    endtask

    initial begin
        i_rst = 1'b1; i_wen = 1'b0; i_ren = 1'b0; i_err_clr = 1'b0; i_data = '0;
        i_af_thresh = 3'd3;
        i_ae_thresh = 3'd1;
        do_reset(1'b0, "reset");

        step(1'b1, 16'h0011, 1'b0, 1'b0, "t1.push");
        step(1'b1, 16'h0022, 1'b0, 1'b0, "t1.push");
        step(1'b1, 16'h0033, 1'b0, 1'b0, "t1.push");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "t1.pop");

        // Fill 0->4 with af=3/ae=1, then push past each capacity.
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0, "t5.fill");
        step(1'b1, 16'h0105, 1'b0, 1'b0, "t2.push5");
        step(1'b1, 16'h0106, 1'b0, 1'b0, "t2.push6");

        for (int i = 0; i < 10; i++) step(1'b1, DW'(16'h0200 + i), 1'b1, 1'b0, "t3.pushpop");
        step(1'b0, '0, 1'b0, 1'b1, "clr");
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, "t2.drain");

        step(1'b0, '0, 1'b1, 1'b0, "t4.under");
        step(1'b0, '0, 1'b1, 1'b1, "t4.clrset");
        step(1'b0, '0, 1'b0, 1'b1, "t4.clr");

        step(1'b1, 16'h0301, 1'b0, 1'b0, "c1.push");
        for (int i = 0; i < 3; i++) step(1'b1, DW'(16'h0310 + i), 1'b1, 1'b0, "c1.pushpop");
        step(1'b0, '0, 1'b1, 1'b0, "c1.pop");

        i_af_thresh = 3'd0;
        i_ae_thresh = 3'd0;
        #1;
        check_all("thr.live");
        i_af_thresh = 3'd3;
        i_ae_thresh = 3'd1;

        for (int i = 0; i < 6; i++) step(1'b1, DW'(16'h0400 + i), 1'b0, 1'b0, "t6.fill");
        do_reset(1'b1, "t6.rst");

        for (int i = 0; i < 120; i++) begin
            if (i % 16 == 0) begin
                i_af_thresh = CW'($urandom_range(0, 7));
                i_ae_thresh = CW'($urandom_range(0, 7));
            end
            step(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule
